// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin share of one RAM port between fetch (r0) and load/store (r1),
// with an r1 lock for atomic sequences and a 2-stage tag routing read data back to its issuer.
module ram_port_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  r0_req_i,
   input  logic                  r0_we_i,
   input  logic [ADDR_WIDTH-1:0] r0_addr_i,
   input  logic [DATA_WIDTH-1:0] r0_wdata_i,
   output logic                  r0_gnt_o,
   output logic                  r0_rvalid_o,
   output logic [DATA_WIDTH-1:0] r0_rdata_o,
   input  logic                  r1_req_i,
   input  logic                  r1_we_i,
   input  logic [ADDR_WIDTH-1:0] r1_addr_i,
   input  logic [DATA_WIDTH-1:0] r1_wdata_i,
   input  logic                  r1_lock_i,
   output logic                  r1_gnt_o,
   output logic                  r1_rvalid_o,
   output logic [DATA_WIDTH-1:0] r1_rdata_o,
   output logic                  ram_en_o,
   output logic                  ram_we_o,
   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   output logic [DATA_WIDTH-1:0] ram_wdata_o,
   input  logic [DATA_WIDTH-1:0] ram_rdata_i
);
   localparam logic ARB = 1'b0;
   localparam logic LOCKED = 1'b1;
   logic                  r_state, w_state_nxt;
   logic                  r_ptr, w_ptr_nxt;
   logic                  w_gnt0, w_gnt1;
   logic                  r_en, r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [1:0]            r_tag_v, r_tag_o;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state <= ARB;
         r_ptr   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   // Pointer is frozen while locked, and handed to fetch when the lock is released.
   always_comb begin
      w_state_nxt = w_gnt1 ? (r1_lock_i ? LOCKED : ARB) : r_state;
      w_ptr_nxt = (r_state == ARB) ? (w_gnt0 ? 1'b1 : (w_gnt1 ? 1'b0 : r_ptr))
                                   : ((w_gnt1 && !r1_lock_i) ? 1'b0 : r_ptr);
   end

   always_comb begin
      w_gnt0 = rst_ni && (r_state == ARB) && r0_req_i && (!r1_req_i || !r_ptr);
      w_gnt1 = rst_ni && r1_req_i && ((r_state == LOCKED) || !r0_req_i || r_ptr);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_en    <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_tag_v <= '0;
         r_tag_o <= '0;
      end else begin
         r_en    <= w_gnt0 || w_gnt1;
         r_we    <= w_gnt0 ? r0_we_i : (w_gnt1 ? r1_we_i : 1'b0);
         if (w_gnt0 || w_gnt1) begin
            r_addr  <= w_gnt0 ? r0_addr_i : r1_addr_i;
            r_wdata <= w_gnt0 ? r0_wdata_i : r1_wdata_i;
         end
         r_tag_v <= {r_tag_v[0], (w_gnt0 && !r0_we_i) || (w_gnt1 && !r1_we_i)};
         r_tag_o <= {r_tag_o[0], w_gnt1};
      end
   end

   assign r0_gnt_o    = w_gnt0;
   assign r1_gnt_o    = w_gnt1;
   assign ram_en_o    = r_en;
   assign ram_we_o    = r_we;
   assign ram_addr_o  = r_addr;
   assign ram_wdata_o = r_wdata;
   assign r0_rvalid_o = r_tag_v[1] && !r_tag_o[1];
   assign r1_rvalid_o = r_tag_v[1] && r_tag_o[1];
   assign r0_rdata_o  = ram_rdata_i;
   assign r1_rdata_o  = ram_rdata_i;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed scoreboard bench; reads push (owner, data, cycle) and a
// monitor pops on every rvalid.
module tb_ram_port_arbiter;
   logic        clk = 1'b0, rst_ni = 1'b0;
   logic        r0_req = 0, r0_we = 0, r1_req = 0, r1_we = 0, r1_lock = 0;
   logic [31:0] r0_addr = 0, r0_wdata = 0, r1_addr = 0, r1_wdata = 0;
   logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, ram_en, ram_we;
   logic [31:0] r0_rdata, r1_rdata, ram_addr, ram_wdata, ram_rdata = 0;
   logic [31:0] mem [0:255];
   int          total = 0, bad = 0, cyc = 0;
   logic [97:0] q [$];
   logic [31:0] a0 [0:2];
   logic [31:0] a1 [0:2];
   logic [31:0] d0 [0:2];
   logic [31:0] d1 [0:2];

   ram_port_arbiter dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .r0_req_i(r0_req), .r0_we_i(r0_we), .r0_addr_i(r0_addr), .r0_wdata_i(r0_wdata),
      .r0_gnt_o(r0_gnt), .r0_rvalid_o(r0_rvalid), .r0_rdata_o(r0_rdata),
      .r1_req_i(r1_req), .r1_we_i(r1_we), .r1_addr_i(r1_addr), .r1_wdata_i(r1_wdata),
      .r1_lock_i(r1_lock), .r1_gnt_o(r1_gnt), .r1_rvalid_o(r1_rvalid), .r1_rdata_o(r1_rdata),
      .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
      .ram_rdata_i(ram_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (ram_en && ram_we) mem[ram_addr[7:0]] <= ram_wdata;
      if (ram_en && !ram_we) ram_rdata <= mem[ram_addr[7:0]];
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic push(input logic owner, input logic [31:0] data);
      q.push_back({owner, 1'b0, data, 64'(cyc + 2)});
   endtask

   task automatic gnts(input logic g0, input logic g1);
      @(negedge clk);
      chk("r0_gnt", r0_gnt, g0);
      chk("r1_gnt", r1_gnt, g1);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (r0_rvalid || r1_rvalid) begin
         if (q.size() == 0) chk("spurious_rvalid", {r0_rvalid, r1_rvalid}, 0);
         else begin
            logic [97:0] e;
            e = q.pop_front();
            chk("rvalid_owner", {r0_rvalid, r1_rvalid}, e[97] ? 2'b01 : 2'b10);
            chk("rdata", e[97] ? r1_rdata : r0_rdata, e[95:64]);
            chk("rvalid_cycle", cyc, e[63:0]);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[8'h10] = 32'hDEADBEEF;
      mem[8'h20] = 32'hA0000020; mem[8'h24] = 32'hA0000024; mem[8'h28] = 32'hA0000028;
      mem[8'h30] = 32'hB0000030; mem[8'h34] = 32'hB0000034; mem[8'h38] = 32'hB0000038;
      mem[8'h44] = 32'h44444444; mem[8'h80] = 32'h80808080; mem[8'h84] = 32'h84848484;
      a0[0] = 32'h20; a0[1] = 32'h24; a0[2] = 32'h28;
      a1[0] = 32'h30; a1[1] = 32'h34; a1[2] = 32'h38;
      d0[0] = 32'hA0000020; d0[1] = 32'hA0000024; d0[2] = 32'hA0000028;
      d1[0] = 32'hB0000030; d1[1] = 32'hB0000034; d1[2] = 32'hB0000038;
      // reset with both requesting: no grants, outputs cleared
      r0_req = 1; r1_req = 1;
      tick; tick;
      gnts(0, 0);
      chk("rst_en", ram_en, 0); chk("rst_we", ram_we, 0);
      chk("rst_addr", ram_addr, 0); chk("rst_wdata", ram_wdata, 0);
      chk("rst_rvalid", {r0_rvalid, r1_rvalid}, 0);
      r0_req = 0; r1_req = 0;
      tick; rst_ni = 1;
      // single read
      r0_req = 1; r0_addr = 32'h10;
      gnts(1, 0); push(0, 32'hDEADBEEF);
      tick; r0_req = 0;
      @(negedge clk);
      chk("sr_en", ram_en, 1); chk("sr_we", ram_we, 0); chk("sr_addr", ram_addr, 32'h10);
      tick;
      @(negedge clk);
      chk("sr_en_idle", ram_en, 0);
      tick; tick;
      // contention from reset
      rst_ni = 0; tick; rst_ni = 1;
      r0_req = 1; r1_req = 1;
      for (int k = 0; k < 6; k++) begin
         r0_addr = a0[k/2]; r1_addr = a1[k/2];
         gnts(k % 2 == 0, k % 2 == 1);
         if (k % 2 == 0) push(0, d0[k/2]); else push(1, d1[k/2]);
         tick;
      end
      r0_req = 0; r1_req = 0;
      tick; tick; tick;
      // write then read
      r1_req = 1; r1_we = 1; r1_addr = 32'h40; r1_wdata = 32'h12345678;
      gnts(0, 1);
      tick; r1_req = 0; r1_we = 0; r0_req = 1; r0_addr = 32'h40;
      gnts(1, 0); push(0, 32'h12345678);
      chk("wr_we", ram_we, 1); chk("wr_addr", ram_addr, 32'h40); chk("wr_wdata", ram_wdata, 32'h12345678);
      tick; r0_req = 0;
      @(negedge clk);
      chk("rd_we", ram_we, 0); chk("rd_en", ram_en, 1);
      tick; tick; tick;
      // lock: pointer now favours r1
      r0_req = 1; r0_addr = 32'h44;
      r1_req = 1; r1_lock = 1; r1_addr = 32'h80;
      gnts(0, 1); push(1, 32'h80808080);
      tick; r1_req = 0;
      gnts(0, 0);
      tick; r1_req = 1; r1_we = 1; r1_lock = 0; r1_wdata = 32'hCAFE0001;
      gnts(0, 1);
      tick; r1_we = 0; r1_addr = 32'h84;
      gnts(1, 0); push(0, 32'h44444444);
      tick; r0_req = 0;
      gnts(0, 1); push(1, 32'h84848484);
      tick; r1_req = 0;
      tick; tick; tick;
      // reset one cycle after a read grant: read dropped
      r0_req = 1; r0_addr = 32'h10;
      gnts(1, 0);
      tick; r0_req = 0; rst_ni = 0;
      tick; r0_req = 1; r1_req = 1;
      gnts(0, 0);
      chk("mid_rst_en", ram_en, 0);
      tick; rst_ni = 1;
      gnts(1, 0); push(0, 32'hDEADBEEF);
      tick; r0_req = 0; r1_req = 0;
      tick; tick; tick;
      chk("queue_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
